// File: rtl/fp_posit_pkg.sv
// fp_posit_pkg: shared fp32 field constants, adder status codes, FSM states and posit helpers
// Imported by fp32_to_posit_conv and posit_regime_pack.
package fp_posit_pkg;
  localparam int EXP_BIAS = 127;
  localparam int EXP_MAX = 255;
  localparam int FRAC_W = 23;
  localparam logic [1:0] FLAG_OK = 2'b00;
  localparam logic [1:0] FLAG_OVF = 2'b01;
  localparam logic [1:0] FLAG_UNF = 2'b10;
  localparam logic [1:0] FLAG_NONNORM = 2'b11;
  typedef enum logic [2:0] {IDLE, UNPACK, NORM, BUILD, ROUND, HOLD} state_t;
  function automatic logic [31:0] nar(input int n);
    return 32'd1 << (n - 1);
  endfunction
  function automatic logic [31:0] maxpos(input int n);
    return (32'd1 << (n - 1)) - 32'd1;
  endfunction
  function automatic logic [31:0] minpos(input int n);
    return n > 0 ? 32'd1 : 32'd0;
  endfunction
endpackage

// File: rtl/posit_regime_pack.sv
// posit_regime_pack: combinational posit body builder (regime + exponent + fraction, with guard/sticky)
// Ports:
//   r_i      signed regime value (scale >>> ES)
//   e_i      exponent field (low ES bits used)
//   sig_i    23-bit fraction below the hidden one
//   bits_o   top N-1 magnitude bits (already maxpos/minpos body when saturated)
//   guard_o  first dropped bit
//   sticky_o OR of all remaining dropped bits
//   sat_o    regime alone fills the word; result clamped
module posit_regime_pack #(
  parameter int N = 32,
  parameter int ES = 2
) (
  input  logic signed [8:0] r_i,
  input  logic [2:0]        e_i,
  input  logic [22:0]       sig_i,
  output logic [N-2:0]      bits_o,
  output logic              guard_o,
  output logic              sticky_o,
  output logic              sat_o
);
  import fp_posit_pkg::*;
  localparam int W = N + 27;
  logic neg;
  logic [8:0] k;
  logic [9:0] rl;
  logic [25:0] tail;
  logic [W-1:0] regime, full;
  always_comb begin
    neg = r_i[8];
    k = neg ? 9'(-r_i) : 9'(r_i);
    rl = neg ? {1'b0, k} + 10'd1 : {1'b0, k} + 10'd2;
    regime = neg ? {1'b1, {(W-1){1'b0}}} >> k : ~({W{1'b1}} >> (k + 9'd1));
    // exponent sits directly above the fraction, ES bits wide, left-justified in 26 bits
    tail = ({3'b0, sig_i} | (26'(e_i) << 23)) << (3 - ES);
    full = regime | ({tail, {(W-26){1'b0}}} >> rl);
    sat_o = rl >= 10'(N - 1);
    bits_o = sat_o ? (neg ? {{(N-2){1'b0}}, 1'b1} : '1) : full[W-1 -: N-1];
    guard_o = ~sat_o & full[W-N];
    sticky_o = ~sat_o & |full[W-N-1:0];
  end
endmodule

// File: rtl/fp32_to_posit_conv.sv
// fp32_to_posit_conv: multi-cycle binary32 -> posit<N,ES> converter with valid/ready on both sides
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   in_valid/in_ready          operand handshake
//   in_data, in_flag           binary32 value and adder status code
//   out_valid/out_ready        result handshake
//   out_posit, out_nar, out_sat posit word, NaR marker, clamped-to-maxpos/minpos marker
// Define FP2P_SUBNORMAL_EN to normalise subnormal inputs; otherwise they flush to zero.
module fp32_to_posit_conv #(
  parameter int N = 32,
  parameter int ES = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [31:0]  in_data,
  input  logic [1:0]   in_flag,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_posit,
  output logic         out_nar,
  output logic         out_sat
);
  import fp_posit_pkg::*;
  state_t state_q, state_d;
  logic [31:0] data_q, data_d;
  logic [1:0] flag_q, flag_d;
  logic [23:0] sig_q, sig_d;
  logic signed [8:0] scale_q, scale_d, r;
  logic [2:0] e;
  logic [N-2:0] bits_q, bits_d, pk_bits;
  logic guard_q, guard_d, sticky_q, sticky_d, bsat_q, bsat_d;
  logic pk_guard, pk_sticky, pk_sat;
  logic [N-1:0] posit_q, posit_d, rnd, mag;
  logic nar_q, nar_d, sat_q, sat_d, rovf, rzero;
  logic [7:0] exp_f;
  logic [22:0] frac_f;
  assign exp_f = data_q[30:FRAC_W];
  assign frac_f = data_q[FRAC_W-1:0];
  assign r = scale_q >>> ES;
  assign e = scale_q[2:0] & 3'((1 << ES) - 1);
  posit_regime_pack #(.N(N), .ES(ES)) u_pack (
    .r_i(r), .e_i(e), .sig_i(sig_q[22:0]),
    .bits_o(pk_bits), .guard_o(pk_guard), .sticky_o(pk_sticky), .sat_o(pk_sat)
  );
  assign rnd = {1'b0, bits_q} + N'(guard_q & (sticky_q | bits_q[0]));
  assign rovf = rnd[N-1];
  assign rzero = rnd == '0;
  assign mag = rovf ? N'(maxpos(N)) : rzero ? N'(minpos(N)) : rnd;
  assign in_ready = state_q == IDLE && !rst;
  assign out_valid = state_q == HOLD;
  assign out_posit = posit_q;
  assign out_nar = nar_q;
  assign out_sat = sat_q;
  always_comb begin
    state_d = state_q;
    data_d = data_q;
    flag_d = flag_q;
    sig_d = sig_q;
    scale_d = scale_q;
    bits_d = bits_q;
    guard_d = guard_q;
    sticky_d = sticky_q;
    bsat_d = bsat_q;
    posit_d = posit_q;
    nar_d = nar_q;
    sat_d = sat_q;
    case (state_q)
      IDLE: if (in_valid && in_ready) begin
        data_d = in_data;
        flag_d = in_flag;
        state_d = UNPACK;
      end
      UNPACK: begin
        posit_d = '0;
        nar_d = 1'b0;
        sat_d = 1'b0;
        if (exp_f == 8'(EXP_MAX) || flag_q == FLAG_OVF || flag_q == FLAG_NONNORM) begin
          posit_d = N'(nar(N));
          nar_d = 1'b1;
          state_d = HOLD;
        end else if (exp_f == 8'd0 && frac_f == '0) begin
          state_d = HOLD;
        end else if (exp_f == 8'd0) begin
`ifdef FP2P_SUBNORMAL_EN
          sig_d = {1'b0, frac_f};
          scale_d = 9'(1 - EXP_BIAS);
          state_d = NORM;
`else
          state_d = HOLD;
`endif
        end else begin
          sig_d = {1'b1, frac_f};
          scale_d = 9'({1'b0, exp_f}) - 9'(EXP_BIAS);
          state_d = BUILD;
        end
      end
      NORM: begin
        // the shift that lands the leading one in bit 23 also leaves NORM
        sig_d = sig_q << 1;
        scale_d = scale_q - 9'sd1;
        state_d = sig_q[22] ? BUILD : NORM;
      end
      BUILD: begin
        bits_d = pk_bits;
        guard_d = pk_guard;
        sticky_d = pk_sticky;
        bsat_d = pk_sat;
        state_d = ROUND;
      end
      ROUND: begin
        posit_d = data_q[31] ? -mag : mag;
        nar_d = 1'b0;
        sat_d = bsat_q | rovf | rzero;
        state_d = HOLD;
      end
      HOLD: state_d = out_ready ? IDLE : HOLD;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      data_q <= '0;
      flag_q <= '0;
      sig_q <= '0;
      scale_q <= '0;
      bits_q <= '0;
      guard_q <= 1'b0;
      sticky_q <= 1'b0;
      bsat_q <= 1'b0;
      posit_q <= '0;
      nar_q <= 1'b0;
      sat_q <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q <= data_d;
      flag_q <= flag_d;
      sig_q <= sig_d;
      scale_q <= scale_d;
      bits_q <= bits_d;
      guard_q <= guard_d;
      sticky_q <= sticky_d;
      bsat_q <= bsat_d;
      posit_q <= posit_d;
      nar_q <= nar_d;
      sat_q <= sat_d;
    end
  end
endmodule

// File: tb/tb_fp32_to_posit_conv.sv
// tb_fp32_to_posit_conv: directed self-checking bench for fp32_to_posit_conv (N=32, ES=2)
module tb_fp32_to_posit_conv;
  typedef struct {
    logic [31:0] d;
    logic [1:0] f;
    logic [31:0] p;
    logic nr;
    logic st;
    int lat;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [31:0] in_data = '0;
  logic [1:0] in_flag = '0;
  logic out_valid;
  logic out_ready = 1'b0;
  logic [31:0] out_posit;
  logic out_nar, out_sat;
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  fp32_to_posit_conv #(.N(32), .ES(2)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_flag(in_flag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_posit(out_posit), .out_nar(out_nar), .out_sat(out_sat)
  );
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic run(input logic [31:0] d, input logic [1:0] f, output logic [31:0] p,
                     output logic nr, output logic st, output int lat);
    int w = 0;
    while (!in_ready && w < 50) begin
      step();
      w++;
    end
    in_data = d;
    in_flag = f;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 100) begin
      step();
      lat++;
    end
    if (!out_valid) lat = -1;
    p = out_posit;
    nr = out_nar;
    st = out_sat;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step();
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready got=%b want=0", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    total++; if (out_posit !== 32'h0) begin bad++; $display("FAIL reset_out_posit got=%h want=0", out_posit); end
    total++; if (out_nar !== 1'b0) begin bad++; $display("FAIL reset_out_nar got=%b want=0", out_nar); end
    total++; if (out_sat !== 1'b0) begin bad++; $display("FAIL reset_out_sat got=%b want=0", out_sat); end
    rst = 1'b0;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_release_in_ready got=%b want=1", in_ready); end
  endtask
  task automatic test_normal();
    vec_t v[6] = '{
      '{32'h3F800000, 2'b00, 32'h40000000, 1'b0, 1'b0, 4},
      '{32'h40000000, 2'b00, 32'h48000000, 1'b0, 1'b0, 4},
      '{32'h3F000000, 2'b00, 32'h38000000, 1'b0, 1'b0, 4},
      '{32'hBF800000, 2'b00, 32'hC0000000, 1'b0, 1'b0, 4},
      '{32'h3F800001, 2'b00, 32'h40000010, 1'b0, 1'b0, 4},
      '{32'h3F800003, 2'b00, 32'h40000030, 1'b0, 1'b0, 4}
    };
    logic [31:0] p;
    logic nr, st;
    int lat;
    foreach (v[i]) begin
      run(v[i].d, v[i].f, p, nr, st, lat);
      total++;
      if (p !== v[i].p || nr !== v[i].nr || st !== v[i].st || lat != v[i].lat) begin
        bad++;
        $display("FAIL normal[%0d] in=%h got posit=%h nar=%b sat=%b lat=%0d want posit=%h nar=%b sat=%b lat=%0d",
                 i, v[i].d, p, nr, st, lat, v[i].p, v[i].nr, v[i].st, v[i].lat);
      end
    end
  endtask
  task automatic test_special();
    vec_t v[8] = '{
      '{32'h00000000, 2'b00, 32'h00000000, 1'b0, 1'b0, 2},
      '{32'h80000000, 2'b00, 32'h00000000, 1'b0, 1'b0, 2},
      '{32'h00000000, 2'b10, 32'h00000000, 1'b0, 1'b0, 2},
      '{32'h7F800000, 2'b00, 32'h80000000, 1'b1, 1'b0, 2},
      '{32'h7FC00000, 2'b00, 32'h80000000, 1'b1, 1'b0, 2},
      '{32'hFF800000, 2'b00, 32'h80000000, 1'b1, 1'b0, 2},
      '{32'h3F800000, 2'b11, 32'h80000000, 1'b1, 1'b0, 2},
      '{32'h3F800000, 2'b01, 32'h80000000, 1'b1, 1'b0, 2}
    };
    logic [31:0] p;
    logic nr, st;
    int lat;
    foreach (v[i]) begin
      run(v[i].d, v[i].f, p, nr, st, lat);
      total++;
      if (p !== v[i].p || nr !== v[i].nr || st !== v[i].st || lat != v[i].lat) begin
        bad++;
        $display("FAIL special[%0d] in=%h flag=%b got posit=%h nar=%b sat=%b lat=%0d want posit=%h nar=%b sat=%b lat=%0d",
                 i, v[i].d, v[i].f, p, nr, st, lat, v[i].p, v[i].nr, v[i].st, v[i].lat);
      end
    end
  endtask
  task automatic test_saturate();
    vec_t v[6] = '{
      '{32'h7F7FFFFF, 2'b00, 32'h7FFFFFFF, 1'b0, 1'b1, 4},
      '{32'h79800000, 2'b00, 32'h7FFFFFFF, 1'b0, 1'b1, 4},
      '{32'h77800000, 2'b00, 32'h7FFFFFFC, 1'b0, 1'b0, 4},
      '{32'h05800000, 2'b00, 32'h00000002, 1'b0, 1'b0, 4},
      '{32'h05000000, 2'b00, 32'h00000001, 1'b0, 1'b1, 4},
      '{32'h85000000, 2'b00, 32'hFFFFFFFF, 1'b0, 1'b1, 4}
    };
    logic [31:0] p;
    logic nr, st;
    int lat;
    foreach (v[i]) begin
      run(v[i].d, v[i].f, p, nr, st, lat);
      total++;
      if (p !== v[i].p || nr !== v[i].nr || st !== v[i].st || lat != v[i].lat) begin
        bad++;
        $display("FAIL saturate[%0d] in=%h got posit=%h nar=%b sat=%b lat=%0d want posit=%h nar=%b sat=%b lat=%0d",
                 i, v[i].d, p, nr, st, lat, v[i].p, v[i].nr, v[i].st, v[i].lat);
      end
    end
  endtask
  task automatic test_rounding();
    vec_t v[6] = '{
      '{32'h4B800001, 2'b00, 32'h7F000000, 1'b0, 1'b0, 4},
      '{32'h4B800002, 2'b00, 32'h7F000000, 1'b0, 1'b0, 4},
      '{32'h4B800003, 2'b00, 32'h7F000001, 1'b0, 1'b0, 4},
      '{32'h4B800006, 2'b00, 32'h7F000002, 1'b0, 1'b0, 4},
      '{32'hCB800006, 2'b00, 32'h80FFFFFE, 1'b0, 1'b0, 4},
      '{32'h4BFFFFFF, 2'b00, 32'h7F200000, 1'b0, 1'b0, 4}
    };
    logic [31:0] p;
    logic nr, st;
    int lat;
    foreach (v[i]) begin
      run(v[i].d, v[i].f, p, nr, st, lat);
      total++;
      if (p !== v[i].p || nr !== v[i].nr || st !== v[i].st || lat != v[i].lat) begin
        bad++;
        $display("FAIL rounding[%0d] in=%h got posit=%h nar=%b sat=%b lat=%0d want posit=%h nar=%b sat=%b lat=%0d",
                 i, v[i].d, p, nr, st, lat, v[i].p, v[i].nr, v[i].st, v[i].lat);
      end
    end
  endtask
  task automatic test_subnormal();
`ifdef FP2P_SUBNORMAL_EN
    vec_t v[3] = '{
      '{32'h00000001, 2'b00, 32'h00000001, 1'b0, 1'b1, 27},
      '{32'h80400000, 2'b00, 32'hFFFFFFFF, 1'b0, 1'b1, 5},
      '{32'h00000001, 2'b10, 32'h00000001, 1'b0, 1'b1, 27}
    };
`else
    vec_t v[3] = '{
      '{32'h00000001, 2'b00, 32'h00000000, 1'b0, 1'b0, 2},
      '{32'h80400000, 2'b00, 32'h00000000, 1'b0, 1'b0, 2},
      '{32'h00000001, 2'b10, 32'h00000000, 1'b0, 1'b0, 2}
    };
`endif
    logic [31:0] p;
    logic nr, st;
    int lat;
    foreach (v[i]) begin
      run(v[i].d, v[i].f, p, nr, st, lat);
      total++;
      if (p !== v[i].p || nr !== v[i].nr || st !== v[i].st || lat != v[i].lat) begin
        bad++;
        $display("FAIL subnormal[%0d] in=%h got posit=%h nar=%b sat=%b lat=%0d want posit=%h nar=%b sat=%b lat=%0d",
                 i, v[i].d, p, nr, st, lat, v[i].p, v[i].nr, v[i].st, v[i].lat);
      end
    end
  endtask
  task automatic test_handshake();
    int w = 0;
    in_data = 32'h40000000;
    in_flag = 2'b00;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    while (!out_valid && w < 50) begin
      step();
      w++;
    end
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL hs_valid_timeout got=%b want=1", out_valid); end
    for (int c = 0; c < 5; c++) begin
      step();
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL hs_hold_valid[%0d] got=%b want=1", c, out_valid); end
      total++; if (out_posit !== 32'h48000000) begin bad++; $display("FAIL hs_hold_posit[%0d] got=%h want=48000000", c, out_posit); end
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL hs_hold_in_ready[%0d] got=%b want=0", c, in_ready); end
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL hs_release_valid got=%b want=0", out_valid); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL hs_release_in_ready got=%b want=1", in_ready); end
  endtask
  task automatic test_reset_mid();
    int seen = 0;
    logic [31:0] p;
    logic nr, st;
    int lat;
    in_data = 32'h3F800000;
    in_flag = 2'b00;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    rst = 1'b1;
    step();
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL mid_rst_in_ready got=%b want=0", in_ready); end
    rst = 1'b0;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL mid_rst_release_in_ready got=%b want=1", in_ready); end
    for (int c = 0; c < 8; c++) begin
      if (out_valid === 1'b1) seen++;
      step();
    end
    total++; if (seen != 0) begin bad++; $display("FAIL mid_rst_no_valid got=%0d cycles valid want=0", seen); end
    run(32'h3F000000, 2'b00, p, nr, st, lat);
    total++;
    if (p !== 32'h38000000 || nr !== 1'b0 || st !== 1'b0 || lat != 4) begin
      bad++;
      $display("FAIL mid_rst_after got posit=%h nar=%b sat=%b lat=%0d want posit=38000000 nar=0 sat=0 lat=4", p, nr, st, lat);
    end
  endtask
  initial begin
    test_reset();
    test_normal();
    test_special();
    test_saturate();
    test_rounding();
    test_subnormal();
    test_handshake();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
